// File: rtl/add_seq_ctrl.sv
// Multi-word add sequencer: feeds one 16-bit word per cycle to an external ripple adder.
// Optional subtraction (sub port, ~op_b with initial carry 1) enabled by defining ADD_SEQ_SUB_EN.
module add_seq_ctrl #(
  parameter int unsigned MAX_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               nwords,
`ifdef ADD_SEQ_SUB_EN
  input  logic                     sub,
`endif
  input  logic [16*MAX_WORDS-1:0]  op_a,
  input  logic [16*MAX_WORDS-1:0]  op_b,
  output logic                     busy,
  output logic                     done,
  output logic [16*MAX_WORDS-1:0]  result,
  output logic                     carry_out,
  output logic [15:0]              add_a,
  output logic [15:0]              add_b,
  output logic                     add_cin,
  input  logic [15:0]              add_sum,
  input  logic                     add_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // nwords can name more words than MAX_WORDS provides; clamp to the last real word
  localparam int unsigned LAST_W   = (MAX_WORDS > 4) ? 3 : MAX_WORDS - 1;
  localparam logic [1:0]  LAST_IDX = LAST_W[1:0];

  state_t                         state;
  logic [1:0]                     idx;
  logic [1:0]                     cnt;
  logic                           carry;
  logic [MAX_WORDS-1:0][15:0]     a_w;
  logic [MAX_WORDS-1:0][15:0]     b_w;
  logic [MAX_WORDS-1:0][15:0]     res_w;
  logic                           sub_sel;

`ifdef ADD_SEQ_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign result = res_w;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_w[idx];
      add_b   = b_w[idx];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_w       <= '0;
      b_w       <= '0;
      res_w     <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_w       <= op_a;
            // subtraction stores the one's complement so RUN is identical for both ops
            b_w       <= sub_sel ? ~op_b : op_b;
            cnt       <= (nwords > LAST_IDX) ? LAST_IDX : nwords;
            res_w     <= '0;
            idx       <= '0;
            carry     <= sub_sel;
            carry_out <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          res_w[idx] <= add_sum;
          carry      <= add_cout;
          if (idx == cnt) begin
            carry_out <= add_cout;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
